ps2_packet_sequencer: RTL and testbench
=======================================

# ps2_packet_sequencer

Frame-level controller for the PS/2 mouse input path. It samples the serial `Mouse_Data` line on `Mouse_Clk`, validates each 11-bit frame, assembles 3-byte standard mouse packets, and publishes button state, signed X/Y movement and a click-driven up/down count. The click count is bounded for the 4-digit seven-segment display stage and is what that stage shows.

## Interface
Parameters:
- `COUNT_MAX`, 9999: saturation ceiling of `click_count`; must fit in 16 bits.

Ports:
- `Mouse_Clk`  input  1  PS/2 device clock; all state updates on its falling edge
- `reset`  input  1  asynchronous, active-high; clock `Mouse_Clk`
- `Mouse_Data`  input  1  PS/2 serial data, LSB first
- `btn_left`, `btn_right`, `btn_middle`  output  1 each  button state from last good packet
- `dx`, `dy`  output  9  signed movement {sign, byte}, two's complement
- `x_ovf`, `y_ovf`  output  1 each  overflow flags from last good packet
- `pkt_valid`  output  1  high from a packet's final stop edge until the next start-bit edge
- `frame_err`  output  1  sticky error flag, cleared on next good packet
- `click_count`  output  16  up/down click counter, 0..COUNT_MAX

## Operation
- Frame FSM, one transition per falling edge of `Mouse_Clk`:
  - IDLE: `Mouse_Data`=0 -> DATA, bit counter=0, `pkt_valid`<=0. `Mouse_Data`=1 -> stay.
  - DATA: shift `Mouse_Data` into bit[counter]; after 8th bit -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: `Mouse_Data`=1 and parity ok -> accept byte; else reject. Always -> IDLE.
- Byte index 0..2:
  - Byte 0 accepted only if bit3=1. Otherwise it is discarded and the index stays 0 (resync). No error is raised.
  - Byte 1 = X magnitude; byte 2 = Y magnitude.
  - Accepting byte 2 commits the packet and returns the index to 0.
- Commit, on the same edge:
  - Buttons = byte0[0] left, [1] right, [2] middle.
  - `dx`={byte0[4],byte1}, `dy`={byte0[5],byte2}.
  - `x_ovf`=byte0[6], `y_ovf`=byte0[7].
  - `pkt_valid`<=1, `frame_err`<=0.
- Rejected frame: `frame_err`<=1, byte index<=0. The partial packet is dropped and outputs are unchanged.
- Click count, updated only at commit and based on 0->1 edges vs. previous committed buttons:
  - Left press only: +1, saturating at COUNT_MAX.
  - Right press only: -1, floor 0.
  - Both presses in the same packet: no change.
  - Held buttons do not re-count.
- Reset mid-frame or mid-packet abandons everything: FSM IDLE, byte index 0.

## Timing
- A frame is exactly 11 falling edges: start, 8 data, parity, stop.
- Packet outputs are registered at the 33rd falling edge of a clean packet. No combinational path runs from `Mouse_Data` to any output.
- `pkt_valid` width is measured in edges, not time: it stays high with no further `Mouse_Clk` activity.
- Reset values:
  - All buttons 0.
  - `dx`=`dy`=0.
  - Overflow flags 0.
  - `pkt_valid`=0, `frame_err`=0, `click_count`=0.
  - Previous-button registers 0.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: odd parity is required over 8 data bits plus the parity bit, and a mismatch rejects the frame.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is sampled and ignored; only the stop bit is checked.

## Test plan
- Reset, then send packet 0x09,0x05,0xFB (left pressed, dx=+5, Y sign 0) -> `btn_left`=1, `dx`=9'h005, `dy`=9'h0FB, `pkt_valid`=1, `click_count`=1.
- Send 0x09 again, then 0x08 (left released), then 0x09 -> count goes 1, 1, 2; a held button does not increment.
- Send right-press packet 0x0A with count=0 -> count stays 0. Send left+right press 0x0B from 0x08 -> count unchanged.
- Send byte 0 = 0x01 (bit3=0), then a valid packet -> first byte discarded, valid packet commits normally, `frame_err`=0.
- Send byte with stop bit 0 in the middle of a packet -> `frame_err`=1, outputs held; next clean packet commits and clears `frame_err`.
- With `PS2_PARITY_CHECK_EN` defined, send a wrong-parity byte -> `frame_err`=1. With the macro undefined, the same stimulus commits the packet. Preload count to 9999 and press left -> count stays 9999.

Source files
------------

// File: rtl/ps2_packet_sequencer.sv
// PS/2 mouse frame receiver and 3-byte packet sequencer with a bounded click counter.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity does not hold.
module ps2_packet_sequencer #(
  parameter int unsigned COUNT_MAX = 9999
) (
  input  logic        Mouse_Clk,
  input  logic        reset,
  input  logic        Mouse_Data,
  output logic        btn_left,
  output logic        btn_right,
  output logic        btn_middle,
  output logic [8:0]  dx,
  output logic [8:0]  dy,
  output logic        x_ovf,
  output logic        y_ovf,
  output logic        pkt_valid,
  output logic        frame_err,
  output logic [15:0] click_count
);

  localparam logic [15:0] CntMax = COUNT_MAX[15:0];

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        par_ok_q;
  logic [1:0]  byte_idx_q;
  logic [6:0]  hdr_q;     // byte 0 without its always-one bit 3
  logic [7:0]  x_q;
  logic [2:0]  btn_q;     // {middle, right, left}, doubles as previous-button state
  logic [8:0]  dx_q, dy_q;
  logic        x_ovf_q, y_ovf_q;
  logic        pkt_valid_q, frame_err_q;
  logic [15:0] cnt_q, cnt_d;
  logic        left_press, right_press;

  always_comb begin
    left_press  = hdr_q[0] & ~btn_q[0];
    right_press = hdr_q[1] & ~btn_q[1];
    cnt_d       = cnt_q;
    if (left_press && !right_press && cnt_q < CntMax) begin
      cnt_d = cnt_q + 16'd1;
    end else if (right_press && !left_press && cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(negedge Mouse_Clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      par_ok_q    <= 1'b0;
      byte_idx_q  <= 2'd0;
      hdr_q       <= 7'd0;
      x_q         <= 8'd0;
      btn_q       <= 3'd0;
      dx_q        <= 9'd0;
      dy_q        <= 9'd0;
      x_ovf_q     <= 1'b0;
      y_ovf_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!Mouse_Data) begin
            state_q     <= StData;
            bit_cnt_q   <= 3'd0;
            pkt_valid_q <= 1'b0;
          end
        end
        StData: begin
          shift_q[bit_cnt_q] <= Mouse_Data;
          bit_cnt_q          <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_q <= StParity;
        end
        StParity: begin
`ifdef PS2_PARITY_CHECK_EN
          par_ok_q <= ^{shift_q, Mouse_Data};
`else
          par_ok_q <= 1'b1;
`endif
          state_q <= StStop;
        end
        StStop: begin
          state_q <= StIdle;
          if (Mouse_Data && par_ok_q) begin
            unique case (byte_idx_q)
              2'd0: begin
                // Header without bit 3 set means we are out of sync; drop silently.
                if (shift_q[3]) begin
                  hdr_q      <= {shift_q[7:4], shift_q[2:0]};
                  byte_idx_q <= 2'd1;
                end
              end
              2'd1: begin
                x_q        <= shift_q;
                byte_idx_q <= 2'd2;
              end
              default: begin
                btn_q       <= hdr_q[2:0];
                dx_q        <= {hdr_q[3], x_q};
                dy_q        <= {hdr_q[4], shift_q};
                x_ovf_q     <= hdr_q[5];
                y_ovf_q     <= hdr_q[6];
                pkt_valid_q <= 1'b1;
                frame_err_q <= 1'b0;
                cnt_q       <= cnt_d;
                byte_idx_q  <= 2'd0;
              end
            endcase
          end else begin
            frame_err_q <= 1'b1;
            byte_idx_q  <= 2'd0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign btn_left    = btn_q[0];
  assign btn_right   = btn_q[1];
  assign btn_middle  = btn_q[2];
  assign dx          = dx_q;
  assign dy          = dy_q;
  assign x_ovf       = x_ovf_q;
  assign y_ovf       = y_ovf_q;
  assign pkt_valid   = pkt_valid_q;
  assign frame_err   = frame_err_q;
  assign click_count = cnt_q;

endmodule

// File: tb/tb_ps2_packet_sequencer.sv
// Bench for ps2_packet_sequencer: directed table, corner sequences and random frames
// checked against a queue-based packet model; a second instance uses a ceiling of 3.
module tb_ps2_packet_sequencer;

  logic Mouse_Clk = 1'b1;
  logic reset = 1'b0;
  logic Mouse_Data = 1'b1;

  logic       btn_left, btn_right, btn_middle, x_ovf, y_ovf, pkt_valid, frame_err;
  logic [8:0] dx, dy;
  logic [15:0] click_count;
  logic       s_left, s_right, s_middle, s_xovf, s_yovf, s_pv, s_err;
  logic [8:0] s_dx, s_dy;
  logic [15:0] s_count;

  ps2_packet_sequencer dut (
    .Mouse_Clk(Mouse_Clk), .reset(reset), .Mouse_Data(Mouse_Data),
    .btn_left(btn_left), .btn_right(btn_right), .btn_middle(btn_middle),
    .dx(dx), .dy(dy), .x_ovf(x_ovf), .y_ovf(y_ovf),
    .pkt_valid(pkt_valid), .frame_err(frame_err), .click_count(click_count)
  );

  ps2_packet_sequencer #(.COUNT_MAX(3)) dut_sat (
    .Mouse_Clk(Mouse_Clk), .reset(reset), .Mouse_Data(Mouse_Data),
    .btn_left(s_left), .btn_right(s_right), .btn_middle(s_middle),
    .dx(s_dx), .dy(s_dy), .x_ovf(s_xovf), .y_ovf(s_yovf),
    .pkt_valid(s_pv), .frame_err(s_err), .click_count(s_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0] m_btn;
  logic [8:0] m_dx, m_dy;
  logic [1:0] m_ovf;
  logic       m_pv, m_err;
  int         m_cnt, m_cnt_s;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [2:0]  btn;
    logic [8:0]  dx, dy;
    logic [1:0]  ovf;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_btn = 3'd0; m_dx = 9'd0; m_dy = 9'd0; m_ovf = 2'd0;
    m_pv = 1'b0; m_err = 1'b0; m_cnt = 0; m_cnt_s = 0;
    q.delete();
  endtask

  task automatic model_frame(input logic [7:0] d, input logic par, input logic stop);
    logic ok;
    logic [7:0] h;
    logic lp, rp;
    ok = stop;
`ifdef PS2_PARITY_CHECK_EN
    ok = ok && (^{d, par});
`else
    if (par === 1'bx) ok = 1'b0;
`endif
    m_pv = 1'b0;
    if (!ok) begin
      m_err = 1'b1;
      q.delete();
    end else if (q.size() == 0 && !d[3]) begin
      // resync: header dropped
    end else begin
      q.push_back(d);
      if (q.size() == 3) begin
        h  = q[0];
        lp = h[0] && !m_btn[0];
        rp = h[1] && !m_btn[1];
        if (lp && !rp) begin
          m_cnt   = (m_cnt >= 9999) ? 9999 : m_cnt + 1;
          m_cnt_s = (m_cnt_s >= 3) ? 3 : m_cnt_s + 1;
        end else if (rp && !lp) begin
          if (m_cnt > 0) m_cnt--;
          if (m_cnt_s > 0) m_cnt_s--;
        end
        m_btn = h[2:0];
        m_dx  = {h[4], q[1]};
        m_dy  = {h[5], q[2]};
        m_ovf = {h[7], h[6]};
        m_pv  = 1'b1;
        m_err = 1'b0;
        q.delete();
      end
    end
  endtask

  task automatic send_bit(input logic b);
    Mouse_Data = b;
    #5 Mouse_Clk = 1'b0;
    #5 Mouse_Clk = 1'b1;
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    logic par;
    par = (~^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    Mouse_Data = 1'b1;
    model_frame(d, par, stop);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b0, 1'b1);
    send_frame(b1, 1'b0, 1'b1);
    send_frame(b2, 1'b0, 1'b1);
  endtask

  task automatic check_all(input string tag);
    chk({tag, " btn"}, {btn_middle, btn_right, btn_left}, m_btn);
    chk({tag, " dx"}, dx, m_dx);
    chk({tag, " dy"}, dy, m_dy);
    chk({tag, " ovf"}, {y_ovf, x_ovf}, m_ovf);
    chk({tag, " pkt_valid"}, pkt_valid, m_pv);
    chk({tag, " frame_err"}, frame_err, m_err);
    chk({tag, " count"}, click_count, m_cnt);
    chk({tag, " sat_count"}, s_count, m_cnt_s);
    chk({tag, " sat_btn"}, {s_middle, s_right, s_left}, m_btn);
  endtask

  initial begin
    tbl[0]  = '{8'h09, 8'h05, 8'hFB, 3'b001, 9'h005, 9'h0FB, 2'b00, 16'd1};
    tbl[1]  = '{8'h09, 8'h00, 8'h00, 3'b001, 9'h000, 9'h000, 2'b00, 16'd1};
    tbl[2]  = '{8'h08, 8'h00, 8'h00, 3'b000, 9'h000, 9'h000, 2'b00, 16'd1};
    tbl[3]  = '{8'h09, 8'h00, 8'h00, 3'b001, 9'h000, 9'h000, 2'b00, 16'd2};
    tbl[4]  = '{8'h08, 8'h00, 8'h00, 3'b000, 9'h000, 9'h000, 2'b00, 16'd2};
    tbl[5]  = '{8'h0B, 8'h01, 8'h02, 3'b011, 9'h001, 9'h002, 2'b00, 16'd2};
    tbl[6]  = '{8'h08, 8'h00, 8'h00, 3'b000, 9'h000, 9'h000, 2'b00, 16'd2};
    tbl[7]  = '{8'h0A, 8'h00, 8'h00, 3'b010, 9'h000, 9'h000, 2'b00, 16'd1};
    tbl[8]  = '{8'h08, 8'h00, 8'h00, 3'b000, 9'h000, 9'h000, 2'b00, 16'd1};
    tbl[9]  = '{8'h0A, 8'h00, 8'h00, 3'b010, 9'h000, 9'h000, 2'b00, 16'd0};
    tbl[10] = '{8'h08, 8'h00, 8'h00, 3'b000, 9'h000, 9'h000, 2'b00, 16'd0};
    tbl[11] = '{8'h0A, 8'h00, 8'h00, 3'b010, 9'h000, 9'h000, 2'b00, 16'd0};
    tbl[12] = '{8'h38, 8'h80, 8'h7F, 3'b000, 9'h180, 9'h17F, 2'b00, 16'd0};
    tbl[13] = '{8'hC9, 8'hFF, 8'hFF, 3'b001, 9'h0FF, 9'h0FF, 2'b11, 16'd1};

    reset = 1'b1;
    model_reset();
    #3;
    chk("reset btn", {btn_middle, btn_right, btn_left}, 3'b000);
    chk("reset dx", dx, 9'h000);
    chk("reset dy", dy, 9'h000);
    chk("reset pkt_valid", pkt_valid, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset count", click_count, 16'd0);
    reset = 1'b0;
    #3;

    for (int i = 0; i < 14; i++) begin
      send_packet(tbl[i].b0, tbl[i].b1, tbl[i].b2);
      chk($sformatf("tbl%0d btn", i), {btn_middle, btn_right, btn_left}, tbl[i].btn);
      chk($sformatf("tbl%0d dx", i), dx, tbl[i].dx);
      chk($sformatf("tbl%0d dy", i), dy, tbl[i].dy);
      chk($sformatf("tbl%0d ovf", i), {y_ovf, x_ovf}, tbl[i].ovf);
      chk($sformatf("tbl%0d count", i), click_count, tbl[i].cnt);
      chk($sformatf("tbl%0d pkt_valid", i), pkt_valid, 1'b1);
      chk($sformatf("tbl%0d frame_err", i), frame_err, 1'b0);
      check_all($sformatf("tbl%0d model", i));
    end

    // pkt_valid persists across idle edges, drops at the next start bit
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("idle pkt_valid", pkt_valid, 1'b1);
    send_frame(8'h01, 1'b0, 1'b1);
    chk("resync pkt_valid", pkt_valid, 1'b0);
    chk("resync frame_err", frame_err, 1'b0);
    check_all("resync hdr");
    send_packet(8'h09, 8'h03, 8'h04);
    chk("resync dx", dx, 9'h003);
    chk("resync err", frame_err, 1'b0);
    check_all("resync pkt");

    send_frame(8'h09, 1'b0, 1'b1);
    send_frame(8'h05, 1'b0, 1'b0);
    chk("stop err flag", frame_err, 1'b1);
    chk("stop err dy held", dy, 9'h004);
    check_all("stop err");
    send_packet(8'h08, 8'h01, 8'h01);
    chk("stop recover err", frame_err, 1'b0);
    check_all("stop recover");

    send_frame(8'h09, 1'b0, 1'b1);
    send_frame(8'h05, 1'b1, 1'b1);
    send_frame(8'h06, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    chk("parity err flag", frame_err, 1'b1);
    chk("parity dx held", dx, 9'h001);
`else
    chk("parity ignored dx", dx, 9'h005);
    chk("parity ignored dy", dy, 9'h006);
`endif
    check_all("parity");

    // Reset in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    model_reset();
    #2;
    chk("midreset count", click_count, 16'd0);
    check_all("midreset");
    reset = 1'b0;
    #3;
    send_packet(8'h09, 8'h01, 8'h02);
    chk("postreset count", click_count, 16'd1);
    check_all("postreset");

    for (int n = 0; n < 300; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[3] = 1'b1;
      send_frame(d, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) != 0));
      check_all($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
